// File: rtl/leds_pkg.sv
// Shared types and constants for the LED pattern driver.
// Modes, bounce direction and prescaler divide helper.
package leds_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_ROTATE = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_e;

  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;

  function automatic int unsigned leds_div(
    input int unsigned clk_hz,
    input int unsigned step_hz
  );
    return clk_hz / step_hz;
  endfunction

endpackage

// File: rtl/leds_if.sv
// User-side bundle of the LED pattern driver.
// master = user logic, slave = the driver.
interface leds_if #(
  parameter int unsigned N_LEDS   = 8,
  parameter int unsigned PWM_BITS = 4
);
  logic                en;
  logic                load;
  logic [N_LEDS-1:0]   pattern;
  logic [1:0]          mode;
  logic [PWM_BITS-1:0] brightness;
  logic [N_LEDS-1:0]   leds;
  logic                tick;

  modport master (
    output en, load, pattern, mode, brightness,
    input  leds, tick
  );

  modport slave (
    input  en, load, pattern, mode, brightness,
    output leds, tick
  );
endinterface

// File: rtl/leds_tick_gen.sv
// Animation prescaler: one-cycle step every DIV enabled cycles.
// clr restarts the count from zero.
module leds_tick_gen #(
  parameter int unsigned DIV = 8
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  input  logic clr,
  output logic step
);
  localparam int unsigned W =
    (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] r_presc;

  assign step = en && (r_presc == LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_presc <= '0;
    end else if (clr) begin
      r_presc <= '0;
    end else if (step) begin
      r_presc <= '0;
    end else if (en) begin
      r_presc <= r_presc + W'(1);
    end
  end
endmodule

// File: rtl/leds_pattern.sv
// Loadable LED pattern with static/blink/rotate/bounce
// animation and a global PWM brightness gate.
module leds_pattern
  import leds_pkg::*;
#(
  parameter int unsigned N_LEDS   = 8,
  parameter int unsigned CLK_HZ   = 12_000_000,
  parameter int unsigned STEP_HZ  = 4,
  parameter int unsigned PWM_BITS = 4
) (
  input logic   clk,
  input logic   rstn,
  leds_if.slave bus
);
  localparam int unsigned DIV =
    leds_div(CLK_HZ, STEP_HZ);

  logic                w_step;
  logic                w_adv;
  mode_e               w_mode;
  logic [N_LEDS-1:0]   w_pat_nxt;
  logic                w_phase_nxt;
  logic                w_dir_nxt;
  logic [N_LEDS-1:0]   w_disp;
  logic                w_gate;

  logic [N_LEDS-1:0]   r_pat;
  logic                r_phase;
  logic                r_dir;
  logic [PWM_BITS-1:0] r_pwm;
  logic [N_LEDS-1:0]   r_leds;
  logic                r_tick;

  leds_tick_gen #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rstn (rstn),
    .en   (bus.en),
    .clr  (bus.load),
    .step (w_step)
  );

  // a load in the step cycle swallows that step
  assign w_adv  = w_step && !bus.load;
  assign w_mode = mode_e'(bus.mode);

  always_comb begin
    w_pat_nxt   = r_pat;
    w_phase_nxt = r_phase;
    w_dir_nxt   = r_dir;
    if (bus.load) begin
      w_pat_nxt   = bus.pattern;
      w_phase_nxt = 1'b0;
      w_dir_nxt   = LEFT;
    end else if (w_adv) begin
      unique case (w_mode)
        MODE_STATIC: w_phase_nxt = 1'b0;
        MODE_BLINK:  w_phase_nxt = ~r_phase;
        MODE_ROTATE: begin
          w_pat_nxt = {r_pat[N_LEDS-2:0],
                       r_pat[N_LEDS-1]};
          w_phase_nxt = 1'b0;
        end
        MODE_BOUNCE: begin
          if (r_dir == LEFT) begin
            if (r_pat[N_LEDS-1]) begin
              w_dir_nxt = RIGHT;
              w_pat_nxt = r_pat >> 1;
            end else begin
              w_pat_nxt = r_pat << 1;
            end
          end else begin
            if (r_pat[0]) begin
              w_dir_nxt = LEFT;
              w_pat_nxt = r_pat << 1;
            end else begin
              w_pat_nxt = r_pat >> 1;
            end
          end
        end
      endcase
    end
    w_disp = (w_mode == MODE_BLINK && w_phase_nxt)
           ? '0 : w_pat_nxt;
    w_gate = (bus.brightness == '1)
          || (r_pwm < bus.brightness);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pat   <= '0;
      r_phase <= 1'b0;
      r_dir   <= LEFT;
      r_pwm   <= '0;
      r_leds  <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_pat   <= w_pat_nxt;
      r_phase <= w_phase_nxt;
      r_dir   <= w_dir_nxt;
      r_pwm   <= r_pwm + PWM_BITS'(1);
      r_leds  <= w_disp & {N_LEDS{w_gate}};
      r_tick  <= w_adv;
    end
  end

  assign bus.leds = r_leds;
  assign bus.tick = r_tick;
endmodule

// File: doc/leds_pattern.md
Name: leds_pattern

Overview:
- Parametrised successor to the fixed-value board LED driver: drives N_LEDS outputs from a loadable pattern register.
- Four animation modes are stepped by an internal prescaled tick: static, blink, rotate and bounce.
- A global PWM brightness gate applies to all outputs.
- Sits between the board top level and the LED pins; the user logic loads a pattern and selects a mode.

Parameters:
- N_LEDS, 8, number of LED outputs (≥2).
- CLK_HZ, 12_000_000, input clock frequency.
- STEP_HZ, 4, animation step rate; DIV = CLK_HZ/STEP_HZ (integer, ≥2).
- PWM_BITS, 4, brightness resolution.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset, asynchronous assert, active-low.
- en  in  1  animation enable; 0 freezes the prescaler and the animation state.
- load  in  1  single-cycle strobe; captures pattern.
- pattern  in  N_LEDS  value to load.
- mode  in  2  0 STATIC, 1 BLINK, 2 ROTATE, 3 BOUNCE.
- brightness  in  PWM_BITS  duty control; 0 = off, all-ones = fully on.
- leds  out  N_LEDS  registered LED drive, 1 = lit.
- tick  out  1  registered one-cycle pulse, asserted in the same cycle leds first shows a new step.

Behaviour:
- Interface (already decided): one clock, clk; reset rstn is asynchronous and active-low.
- Reset values: leds=0, tick=0, pat_q=0, presc=0, phase=0, dir=LEFT, pwm_cnt=0.
- Prescaler:
  - presc counts 0..DIV-1 while en=1.
  - step is asserted (combinationally) when presc==DIV-1 && en; presc then wraps to 0.
  - en=0 holds presc.
- load has priority over step in the same cycle:
  - pat_q<=pattern, presc<=0, phase<=0, dir<=LEFT.
  - No animation update occurs in that cycle.
- On step, by mode sampled in that cycle:
  - STATIC: pat_q unchanged; phase<=0.
  - BLINK: phase<=~phase; pat_q unchanged.
  - ROTATE: pat_q<={pat_q[N-2:0],pat_q[N-1]}; phase<=0.
  - BOUNCE, dir LEFT: if pat_q[N-1] then dir<=RIGHT and pat_q<=pat_q>>1, else pat_q<=pat_q<<1.
  - BOUNCE, dir RIGHT: if pat_q[0] then dir<=LEFT and pat_q<=pat_q<<1, else pat_q<=pat_q>>1.
  - BOUNCE: bits shifted off the end are lost. pat_q=0 stays 0 and dir does not change.
  - dir changes only in BOUNCE mode.
- Mode changes take effect at the next step. No state is reset except phase as listed above.
- Display value: disp = (mode==BLINK && phase) ? 0 : pat_q.
- PWM:
  - pwm_cnt increments every clk and wraps modulo 2^PWM_BITS, regardless of en.
  - gate = (brightness=={PWM_BITS{1}}) || (pwm_cnt < brightness).
  - brightness=b, with b below all-ones, gives exactly b on-cycles per 2^PWM_BITS window.
- Output register: leds <= disp & {N_LEDS{gate}}, using post-update state. leds therefore reflects a load or step 1 cycle after the strobe/step cycle.
- tick <= step registered, aligned with the leds change.
- Reset mid-animation: all state returns to reset values immediately, asynchronously. The first step after release occurs DIV cycles after the first enabled cycle.

Decomposition:
- Package leds_pkg:
  - mode enum (MODE_STATIC, MODE_BLINK, MODE_ROTATE, MODE_BOUNCE).
  - dir constants LEFT/RIGHT.
  - helper function for DIV computation.
- Sub-module leds_tick_gen: prescaler with inputs clk, rstn, en, clr (=load) and output step; parameter DIV.
- The pattern/mode FSM and PWM stay in leds_pattern.

Test Plan:
Bench parameters: N_LEDS=8, CLK_HZ=8, STEP_HZ=1 (DIV=8), PWM_BITS=4, brightness=15 unless stated.
1. Reset, then load 0xA5, mode=STATIC, en=1 -> leds=0xA5 one cycle after load and unchanged for 64 cycles; tick pulses every 8 cycles.
2. Load 0x81, mode=ROTATE -> successive ticks show leds 0x03, 0x06, 0x0C, …, 0xC0, 0x81; the step after 0xC0 yields 0x81 (MSB wraps to LSB).
3. Load 0x01, mode=BOUNCE -> ticks show 0x02, 0x04, …, 0x80, 0x40, 0x20, …, 0x01, 0x02; the direction reverses at both ends with no repeated value.
4. Load 0xFF, mode=BLINK -> leds alternate 0x00/0xFF on each tick. A load asserted on the exact step cycle wins: leds shows the new pattern, phase=0, and the next tick arrives 8 cycles later.
5. en=0 for 20 cycles mid-ROTATE -> no tick and leds frozen; after en returns to 1, the next tick comes exactly after the remaining prescaler count. brightness=4 -> leds=pattern for 4 of every 16 cycles; brightness=0 -> leds=0 constantly.
6. Assert rstn=0 asynchronously mid-BOUNCE in dir RIGHT -> leds=0 and tick=0 immediately. After release, load 0x01 -> the first step moves LEFT (0x02).
